// File: rtl/fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader_if
// Bundles the FIFO read port and the valid/ready output stream handled by
// fifo_stream_reader.
//   master : the reader itself (drives fifo_rd_en and the stream outputs)
//   slave  : its surroundings (FIFO read side plus downstream consumer)
// Signals:
//   fifo_rd_en    read strobe toward the FIFO
//   fifo_data_out FIFO read data, valid the cycle after an accepted read
//   fifo_empty    FIFO empty flag
//   m_data        stream data (head of the output buffer)
//   m_valid       output buffer holds at least one word
//   m_ready       consumer ready
//   occupancy     words held in the output buffer (0..2)
//   xfer_count    completed transfers (only with FIFO_RD_XFER_CNT_EN)
// Optional feature macro: FIFO_RD_XFER_CNT_EN
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [1:0]            occupancy;
`ifdef FIFO_RD_XFER_CNT_EN
    logic [15:0]           xfer_count;
`endif

    modport master (
`ifdef FIFO_RD_XFER_CNT_EN
        output xfer_count,
`endif
        output fifo_rd_en, m_data, m_valid, occupancy,
        input  fifo_data_out, fifo_empty, m_ready
    );

    modport slave (
`ifdef FIFO_RD_XFER_CNT_EN
        input  xfer_count,
`endif
        input  fifo_rd_en, m_data, m_valid, occupancy,
        output fifo_data_out, fifo_empty, m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Drains a synchronous FIFO (rd_en / data_out / empty, one-cycle read
// latency) and presents the words as a valid/ready stream. A 2-entry
// circular output buffer hides the read latency so the stream sustains one
// word per cycle while m_ready stays high.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset; clears all state and the buffer
//   bus  fifo_stream_reader_if.master (FIFO read port + output stream)
// Optional feature macro: FIFO_RD_XFER_CNT_EN adds a 16-bit wrapping
// transfer counter on bus.xfer_count.
// fifo_rd_en is combinational (depends on m_ready); all other outputs come
// straight from registers.
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_stream_reader_if.master   bus
);
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic                  pop;
    logic [2:0]            level;
    logic                  rd_en;
`ifdef FIFO_RD_XFER_CNT_EN
    logic [15:0]           xfer_q, xfer_d;
`endif

    always_comb begin
        pop   = (occ_q != 2'd0) && bus.m_ready;
        // Words committed to the buffer after this edge, counting the read
        // already in flight; a new read is only issued if it still fits.
        level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        rd_en = !rst && !bus.fifo_empty && (level < 3'd2);

        mem_d  = mem_q;
        tail_d = tail_q;
        if (inflight_q) begin
            mem_d[tail_q] = bus.fifo_data_out;
            tail_d        = ~tail_q;
        end
        head_d = pop ? ~head_q : head_q;
        occ_d  = level[1:0];
`ifdef FIFO_RD_XFER_CNT_EN
        xfer_d = pop ? xfer_q + 16'd1 : xfer_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
`ifdef FIFO_RD_XFER_CNT_EN
            xfer_q     <= 16'd0;
`endif
        end else begin
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en;
`ifdef FIFO_RD_XFER_CNT_EN
            xfer_q     <= xfer_d;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = mem_q[head_q];
    assign bus.occupancy  = occ_q;
`ifdef FIFO_RD_XFER_CNT_EN
    assign bus.xfer_count = xfer_q;
`endif
endmodule
